// File: rtl/bitrev_buf_pkg.sv
// Shared definitions for the bit-reversal ping-pong buffer: default sizing
// and the address bit-reverse helper used on the read side.
package bitrev_buf_pkg;

    // Default sample component width exponent (2**4 = 16-bit components).
    localparam int DEF_N       = 4;
    // Default frame length exponent (2**3 = 8 complex samples per frame).
    localparam int DEF_LOG_PTS = 3;
    // Widest address the bit-reverse helper handles.
    localparam int BR_MAXW     = 16;

    // Reverse the low log_pts bits of value; bits above log_pts come back zero.
    // Built as a shift chain so no variable bit-select is needed.
    function automatic logic [BR_MAXW-1:0] bit_reverse(
        input logic [BR_MAXW-1:0] value,
        input int                 log_pts
    );
        logic [BR_MAXW-1:0] src;
        logic [BR_MAXW-1:0] res;
        src = value;
        res = '0;
        for (int i = 0; i < BR_MAXW; i++) begin
            if (i < log_pts) begin
                res = {res[BR_MAXW-2:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bitrev_buf_bank.sv
// One bank of the ping-pong buffer: synchronous write, asynchronous read.
module bitrev_bank
    import bitrev_buf_pkg::*;
#(
    parameter int LOG_PTS = DEF_LOG_PTS,
    parameter int WIDTH   = 2 * (2 ** DEF_N)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [LOG_PTS-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [LOG_PTS-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] mem_q [2**LOG_PTS];

    // Store the incoming {re, im} word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bitrev_buf.sv
// Ping-pong frame buffer that re-emits each frame of complex samples in
// bit-reversed address order, feeding a downstream rotation stage.
// Optional feature: define BITREV_BUF_FRAME_FLAGS_EN to add out_sof/out_eof
// start/end-of-frame markers aligned with out_re/out_im.
module bitrev_buf
    import bitrev_buf_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int LOG_PTS = DEF_LOG_PTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2**N-1:0]   in_re,
    input  logic [2**N-1:0]   in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   out_re,
`ifdef BITREV_BUF_FRAME_FLAGS_EN
    output logic              out_sof,
    output logic              out_eof,
`endif
    output logic [2**N-1:0]   out_im
);

    localparam int                 W    = 2 ** N;
    localparam int                 PTS  = 2 ** LOG_PTS;
    localparam logic [LOG_PTS-1:0] LAST = LOG_PTS'(PTS - 1);

    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [1:0]         full_q, full_d;
    logic [LOG_PTS-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG_PTS-1:0] rd_cnt_q, rd_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_re_q, out_re_d;
    logic [W-1:0]       out_im_q, out_im_d;
`ifdef BITREV_BUF_FRAME_FLAGS_EN
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
`endif

    logic               in_fire;
    logic               load_en;
    logic               rd_fire;
    logic               wr_last;
    logic               rd_last;
    logic [LOG_PTS-1:0] rd_addr;
    logic [2*W-1:0]     bank_rd_data [2];
    logic [2*W-1:0]     rd_word;

    assign in_ready = ~full_q[wr_bank_q];
    assign in_fire  = in_valid & in_ready;
    // The output register may take a new value when empty or being drained.
    assign load_en  = ~out_valid_q | out_ready;
    assign rd_fire  = load_en & full_q[rd_bank_q];
    assign wr_last  = in_fire & (wr_cnt_q == LAST);
    assign rd_last  = rd_fire & (rd_cnt_q == LAST);
    assign rd_addr  = LOG_PTS'(bit_reverse(BR_MAXW'(rd_cnt_q), LOG_PTS));
    assign rd_word  = bank_rd_data[rd_bank_q];

    // Two banks; each sets its full flag on its last write and clears it on
    // its last read. A bank is never written and read-completed together
    // because the write bank is by definition not full.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        bitrev_bank #(
            .LOG_PTS (LOG_PTS),
            .WIDTH   (2 * W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (in_fire & (wr_bank_q == 1'(gi))),
            .wr_addr (wr_cnt_q),
            .wr_data ({in_re, in_im}),
            .rd_addr (rd_addr),
            .rd_data (bank_rd_data[gi])
        );

        assign full_d[gi] = (full_q[gi] | (wr_last & (wr_bank_q == 1'(gi))))
                          & ~(rd_last & (rd_bank_q == 1'(gi)));
    end

    // Write side: advance the write address and flip banks after the last slot.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + LOG_PTS'(1);
            if (wr_cnt_q == LAST) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
    end

    // Read side: load the output stage from the full bank in bit-reversed order.
    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
`ifdef BITREV_BUF_FRAME_FLAGS_EN
        sof_d       = sof_q;
        eof_d       = eof_q;
`endif
        if (load_en) begin
            out_valid_d = rd_fire;
            if (rd_fire) begin
                out_re_d = rd_word[2*W-1:W];
                out_im_d = rd_word[W-1:0];
                rd_cnt_d = rd_cnt_q + LOG_PTS'(1);
`ifdef BITREV_BUF_FRAME_FLAGS_EN
                sof_d    = (rd_cnt_q == '0);
                eof_d    = (rd_cnt_q == LAST);
`endif
                if (rd_cnt_q == LAST) begin
                    rd_bank_d = ~rd_bank_q;
                end
            end
        end
    end

    // State register with synchronous active-low reset; bank contents are kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
`ifdef BITREV_BUF_FRAME_FLAGS_EN
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
`endif
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
`ifdef BITREV_BUF_FRAME_FLAGS_EN
            sof_q       <= sof_d;
            eof_q       <= eof_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
`ifdef BITREV_BUF_FRAME_FLAGS_EN
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;
`endif

endmodule

// File: tb/tb_bitrev_buf.sv
// Directed bench for bitrev_buf (default N=4, LOG_PTS=3). Expected output
// order comes from a hand-written bit-reversal table and a frame scoreboard.
module tb_bitrev_buf;

    localparam int W   = 16;
    localparam int PTS = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
`ifdef BITREV_BUF_FRAME_FLAGS_EN
    logic         out_sof;
    logic         out_eof;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int frame_buf[PTS];
    int in_pos = 0;
    int out_pos = 0;
    int next_val = 0;
    int ord[PTS] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    bitrev_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
`ifdef BITREV_BUF_FRAME_FLAGS_EN
        .out_sof   (out_sof),
        .out_eof   (out_eof),
`endif
        .out_im    (out_im)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_val();
        in_re = W'(next_val);
        in_im = W'(next_val + 100);
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_pos  = 0;
        out_pos = 0;
    endtask

    // One clock: score handshakes seen before the edge, then step past it.
    task automatic tick();
        logic in_fire;
        logic out_fire;
        int   e;
        #1;
        in_fire  = in_valid && in_ready && rst;
        out_fire = out_valid && out_ready && rst;
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_re", 32'(out_re), 32'(e % 65536));
                check("out_im", 32'(out_im), 32'((e + 100) % 65536));
`ifdef BITREV_BUF_FRAME_FLAGS_EN
                check("out_sof", 32'(out_sof), 32'(out_pos == 0));
                check("out_eof", 32'(out_eof), 32'(out_pos == PTS - 1));
`endif
                out_pos = (out_pos + 1) % PTS;
            end
        end
        if (in_fire) begin
            frame_buf[in_pos] = int'(in_re);
            in_pos++;
            if (in_pos == PTS) begin
                for (int k = 0; k < PTS; k++) exp_q.push_back(frame_buf[ord[k]]);
                in_pos = 0;
            end
        end
        @(posedge clk);
        #1;
        if (in_fire) begin
            next_val++;
            drive_val();
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        drive_val();
        rst = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_re", 32'(out_re), 32'd0);
        check("rst_out_im", 32'(out_im), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;

        // One frame 0..7, latency and bit-reversed order
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < PTS; i++) tick();
        check("lat_pre", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        check("lat_first_valid", 32'(out_valid), 32'd1);
        check("lat_first_re", 32'(out_re), 32'd0);
        drain("drain_frame1");
        tick();
        check("idle_after_frame1", 32'(out_valid), 32'd0);

        // Four back-to-back frames, no bubbles
        for (int t = 1; t <= 41; t++) begin
            in_valid = (t <= 32);
            if (t <= 32) check("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (t >= 9 && t <= 40) check("stream_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        drain("drain_stream");

        // Backpressure: both banks fill, 17th sample is held
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        next_val = 0;
        drive_val();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 40 && next_val < 16; i++) tick();
        check("fill16", 32'(next_val), 32'd16);
        check("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_re", 32'(out_re), 32'd0);
            check("held17", 32'(next_val), 32'd16);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 100 && next_val < 24; i++) tick();
        in_valid = 1'b0;
        check("fill24", 32'(next_val), 32'd24);
        drain("drain_backpressure");

        // Random handshakes over 10 frames
        for (int i = 0; i < 3000 && next_val < 104; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        check("rand_accepted", 32'(next_val), 32'd104);
        drain("drain_random");
        tick();
        check("idle_after_random", 32'(out_valid), 32'd0);

        // Partial frame held, then reset mid-frame
        next_val = 0;
        drive_val();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("partial_hold", 32'(out_valid), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        next_val = 8;
        drive_val();
        in_valid = 1'b1;
        for (int i = 0; i < PTS; i++) tick();
        in_valid = 1'b0;
        tick();
        check("after_rst_first_re", 32'(out_re), 32'd8);
        drain("drain_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
